// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared types and defaults for the posted-write store buffer.
//   sb_entry_t   - one queued store {addr, data}, sized by the package defaults.
//   SB_DEPTH, SB_ADDR_W, SB_DATA_W - default parameter values.
//   sb_ptr_w()   - pointer width for a given power-of-two depth.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH  = 4;
  localparam int unsigned SB_ADDR_W = 32;
  localparam int unsigned SB_DATA_W = 32;

  // Entry storage; instance ADDR_W/DATA_W must not exceed these widths.
  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  function automatic int unsigned sb_ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: store-to-load forwarding lookup across the buffer entries.
//   ents_i    - entry array (indexed by physical slot)
//   valid_i   - per-slot valid mask
//   wp_i      - write pointer; slot wp_i-1 is the youngest entry
//   ld_addr_i - load address, compared on word granularity (bits [ADDR_W-1:2])
//   hit_o     - any valid entry matches
//   data_o    - data of the youngest matching entry
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH,
  parameter int unsigned ADDR_W = SB_ADDR_W,
  parameter int unsigned DATA_W = SB_DATA_W
) (
  input  sb_entry_t                          ents_i [DEPTH],
  input  logic [DEPTH-1:0]                   valid_i,
  input  logic [sb_ptr_w(DEPTH)-1:0]         wp_i,
  input  logic [ADDR_W-1:0]                  ld_addr_i,
  output logic                               hit_o,
  output logic [DATA_W-1:0]                  data_o
);

  localparam int unsigned PTR_W = sb_ptr_w(DEPTH);

  // Walk slots oldest-position (wp) to youngest (wp-1); later matches overwrite,
  // so the youngest matching entry wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = wp_i + PTR_W'(k);
      if (valid_i[idx] &&
          ((ld_addr_i >> 2) == (ADDR_W'(ents_i[idx].addr) >> 2))) begin
        hit_o  = 1'b1;
        data_o = DATA_W'(ents_i[idx].data);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the core store port and a
// valid/ready data-memory bus. Stores retire in one cycle and drain in order.
//   clk, reset (async, active low)
//   MemWrite/DataAdr/WriteData - core store request; held by the core while stall
//   stall                      - buffer full
//   mem_valid/mem_ready        - head-entry handshake; mem_addr/mem_wdata = head
//   empty                      - nothing queued
//   ld_addr/ld_hit/ld_data     - store-to-load forwarding lookup
// Optional feature macro: STORE_BUFFER_FWD_EN enables forwarding; without it
// ld_hit/ld_data are tied low and no comparators are built.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH,
  parameter int unsigned ADDR_W = SB_ADDR_W,
  parameter int unsigned DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              stall,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              empty,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data
);

  localparam int unsigned PTR_W = sb_ptr_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  sb_entry_t        ent_q [DEPTH];

  logic full, push, pop;

  // Status derived purely from registered occupancy (no path from MemWrite/mem_ready).
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign stall     = full;
  assign mem_valid = !empty;
  assign push      = MemWrite && !full;
  assign pop       = mem_valid && mem_ready;

  // Head entry, masked while empty since entry storage is never reset.
  assign mem_addr  = empty ? '0 : ADDR_W'(ent_q[rp_q].addr);
  assign mem_wdata = empty ? '0 : DATA_W'(ent_q[rp_q].data);

  // Next-state for pointers and occupancy.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push) wp_d = wp_q + PTR_W'(1);
    if (pop)  rp_d = rp_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy state; reset discards all queued stores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Entry storage: written on push only, contents survive reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_q[wp_q] <= '{addr: SB_ADDR_W'(DataAdr), data: SB_DATA_W'(WriteData)};
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [DEPTH-1:0] valid_c;

  // Slot i is live when its distance from rp is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] off;
    valid_c = '0;
    off     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off        = PTR_W'(i) - rp_q;
      valid_c[i] = (CNT_W'(off) < count_q);
    end
  end

  sb_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd (
    .ents_i    (ent_q),
    .valid_i   (valid_c),
    .wp_i      (wp_q),
    .ld_addr_i (ld_addr),
    .hit_o     (ld_hit),
    .data_o    (ld_data)
  );
`else
  logic unused_ld_addr;

  assign unused_ld_addr = ^ld_addr;
  assign ld_hit         = 1'b0;
  assign ld_data        = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer. The driver keeps a queue
// model of buffered stores, predicts acceptance and pushes accepted stores to a
// scoreboard; a monitor pops the scoreboard on every memory handshake.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          MemWrite = 1'b0;
  logic [AW-1:0] DataAdr = '0;
  logic [DW-1:0] WriteData = '0;
  logic          stall;
  logic          mem_valid;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          empty;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_hit;
  logic [DW-1:0] ld_data;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .stall     (stall),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .empty     (empty),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sb_entry_t model_q [$];  // stores currently held by the buffer, oldest first
  sb_entry_t exp_q   [$];  // scoreboard: stores expected on the memory bus

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest queued store to the same word wins.
  function automatic void fwd_model(input logic [AW-1:0] la, output logic h, output logic [DW-1:0] d);
    logic          hm;
    logic [DW-1:0] dm;
    hm = 1'b0;
    dm = '0;
    foreach (model_q[i]) begin
      if (model_q[i].addr[AW-1:2] == la[AW-1:2]) begin
        hm = 1'b1;
        dm = model_q[i].data;
      end
    end
    h = FWD_ON && hm;
    d = FWD_ON ? dm : '0;
  endfunction

  // One core cycle: check state left by the last edge, then drive the next request.
  task automatic cycle(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic rdy, input logic [AW-1:0] la, output bit acc);
    logic          h;
    logic [DW-1:0] fd;
    int            occ;
    @(negedge clk);
    #1;
    occ = model_q.size();
    chk("stall", stall, occ == DEPTH);
    chk("empty", empty, occ == 0);
    chk("mem_valid", mem_valid, occ != 0);
    if (occ == 0) begin
      chk("mem_addr_idle", mem_addr, 0);
      chk("mem_wdata_idle", mem_wdata, 0);
    end
    fwd_model(ld_addr, h, fd);
    chk("ld_hit", ld_hit, h);
    chk("ld_data", ld_data, fd);
    MemWrite  = we;
    DataAdr   = a;
    WriteData = d;
    mem_ready = rdy;
    ld_addr   = la;
    acc = we && (occ != DEPTH);
    if (occ != 0 && rdy) void'(model_q.pop_front());
    if (acc) begin
      model_q.push_back(sb_entry_t'{addr: a, data: d});
      exp_q.push_back(sb_entry_t'{addr: a, data: d});
    end
  endtask

  // Monitor: every handshake must present the oldest outstanding store.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clk);
      #3;
      if (reset && mem_valid && mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drain_unexpected actual=%0h required=none", mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("drain_addr", mem_addr, e.addr);
          chk("drain_data", mem_wdata, e.data);
        end
      end
    end
  end

  initial begin
    bit            acc;
    logic          p_we;
    logic [AW-1:0] p_a;
    logic [DW-1:0] p_d;
    acc = 1'b0;

    // Reset state
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_empty", empty, 1);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_ld_hit", ld_hit, 0);
    #10 reset = 1'b1;

    // Single store with memory ready, then empty again
    cycle(1, 100, 25, 1, 0, acc);
    cycle(0, 0, 0, 1, 0, acc);
    cycle(0, 0, 0, 1, 0, acc);
    cycle(0, 0, 0, 0, 0, acc);

    // Fill with memory stalled; fifth store waits for one ready pulse
    for (int i = 0; i < 4; i++) cycle(1, AW'(96 + 4 * i), DW'(1000 + i), 0, AW'(96 + 4 * i), acc);
    cycle(1, 112, 1004, 0, 112, acc);
    cycle(1, 112, 1004, 1, 112, acc);
    cycle(1, 112, 1004, 0, 112, acc);
    repeat (6) cycle(0, 0, 0, 1, 0, acc);

    // Steady push+pop at occupancy 2, wrapping pointers
    cycle(1, 200, 1, 0, 0, acc);
    cycle(1, 204, 2, 0, 0, acc);
    for (int i = 0; i < 10; i++) cycle(1, AW'(300 + 4 * i), DW'(50 + i), 1, 0, acc);
    repeat (4) cycle(0, 0, 0, 1, 0, acc);

    // Forwarding: two stores to the same word, youngest wins
    cycle(1, 100, 7, 0, 100, acc);
    cycle(1, 100, 25, 0, 100, acc);
    cycle(0, 0, 0, 0, 102, acc);
    cycle(0, 0, 0, 0, 96, acc);
    cycle(0, 0, 0, 1, 100, acc);
    cycle(0, 0, 0, 1, 100, acc);
    cycle(0, 0, 0, 0, 0, acc);

    // Asynchronous reset with three stores queued
    cycle(1, 400, 1, 0, 400, acc);
    cycle(1, 404, 2, 0, 400, acc);
    cycle(1, 408, 3, 0, 400, acc);
    cycle(0, 0, 0, 0, 400, acc);
    #1 reset = 1'b0;
    #1;
    chk("arst_mem_valid", mem_valid, 0);
    chk("arst_empty", empty, 1);
    chk("arst_stall", stall, 0);
    chk("arst_ld_hit", ld_hit, 0);
    chk("arst_ld_data", ld_data, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    model_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    cycle(1, 100, 25, 0, 0, acc);
    cycle(0, 0, 0, 1, 0, acc);
    cycle(0, 0, 0, 1, 0, acc);

    // Randomized traffic; a refused store is held and retried like the core does
    p_we = 1'b0;
    p_a  = '0;
    p_d  = '0;
    acc  = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (!(p_we && !acc)) begin
        p_we = ($urandom_range(0, 99) < 60);
        p_a  = AW'($urandom_range(0, 31));
        p_d  = DW'($urandom);
      end
      cycle(p_we, p_a, p_d, $urandom_range(0, 99) < 45, AW'($urandom_range(0, 31)), acc);
    end
    repeat (DEPTH + 2) cycle(0, 0, 0, 1, 0, acc);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
